// File: rtl/rsp_buff_pkg.sv
// Shared definitions for the controller-to-host response buffer.
// Holds the AXI region code, the register offsets within the response
// region, the status word bit positions, and the offset decode helper.
package rsp_buff_pkg;

  localparam logic [1:0] AXI_RSP_FIFO_REGION = 2'b10;
  localparam logic [3:0] RSP_DATA_OFS        = 4'h0;
  localparam logic [3:0] RSP_STAT_OFS        = 4'h4;

  localparam int RSP_STAT_OVF_BIT   = 31;
  localparam int RSP_STAT_FULL_BIT  = 9;
  localparam int RSP_STAT_EMPTY_BIT = 8;

  typedef enum logic [1:0] {
    RD_DATA = 2'd0,
    RD_STAT = 2'd1,
    RD_BAD  = 2'd2
  } rd_sel_e;

  function automatic rd_sel_e decode_ofs(input logic [3:0] ofs);
    rd_sel_e sel;
    case (ofs)
      RSP_DATA_OFS: sel = RD_DATA;
      RSP_STAT_OFS: sel = RD_STAT;
      default:      sel = RD_BAD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rsp_fifo_core.sv
// Storage, pointers and occupancy count for the response FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (control state only)
//   push       - write push_data at the tail; caller guarantees not full
//   push_data  - word to store
//   pop        - advance the head; caller guarantees not empty
//   head_data  - word at the head of the FIFO
//   count      - number of stored words (0..ENT_NUM)
//   full/empty - count == ENT_NUM / count == 0
module rsp_fifo_core
  import rsp_buff_pkg::*;
#(
  parameter int ENT_NUM   = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_SIZE-1:0]       push_data,
  input  logic                       pop,
  output logic [DATA_SIZE-1:0]       head_data,
  output logic [$clog2(ENT_NUM):0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(ENT_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_SIZE-1:0] mem [ENT_NUM];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because ENT_NUM is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_W'(ENT_NUM));
  assign empty     = (count == '0);

endmodule

// File: rtl/rsp_buff.sv
// Response buffer: the controller pushes result words, the host drains them
// with AXI reads to the response region.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   axi_rd_vld          - single-cycle read request strobe
//   axi_rd_addr         - read address, bits [3:0] pick data (0x0) or status (0x4)
//   axi_rd_region       - region decode; only AXI_RSP_FIFO_REGION is answered
//   axi_rd_data         - read data, valid while axi_rd_done is high
//   axi_rd_done         - one-cycle completion pulse, one cycle after the request
//   axi_rd_err          - SLVERR qualifier for axi_rd_done
//   ctrl_rsp_buff_vld   - controller push strobe
//   ctrl_rsp_buff_data  - controller push word
//   rsp_buff_ctrl_rdy   - FIFO can accept a push this cycle
//   rsp_buff_empty      - FIFO holds no words
module rsp_buff
  import rsp_buff_pkg::*;
#(
  parameter int ARADDR_WIDTH = 11,
  parameter int RDATA_WIDTH  = 32,
  parameter int ENT_NUM      = 4,
  parameter int CNT_WIDTH    = $clog2(ENT_NUM) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axi_rd_vld,
  input  logic [ARADDR_WIDTH-1:0] axi_rd_addr,
  input  logic [1:0]              axi_rd_region,
  output logic [RDATA_WIDTH-1:0]  axi_rd_data,
  output logic                    axi_rd_done,
  output logic                    axi_rd_err,
  input  logic                    ctrl_rsp_buff_vld,
  input  logic [RDATA_WIDTH-1:0]  ctrl_rsp_buff_data,
  output logic                    rsp_buff_ctrl_rdy,
  output logic                    rsp_buff_empty
);

  logic                   rd_qual;
  rd_sel_e                rd_sel;
  logic                   push;
  logic                   pop;
  logic                   ovf;
  logic                   ovf_set;
  logic                   stat_rd;
  logic                   full;
  logic                   empty;
  logic [CNT_WIDTH-1:0]   count;
  logic [RDATA_WIDTH-1:0] head_data;
  logic [RDATA_WIDTH-1:0] stat_word;
  logic [RDATA_WIDTH-1:0] rsp_data;
  logic                   rsp_err;
  logic                   unused_addr;

  assign unused_addr = ^axi_rd_addr[ARADDR_WIDTH-1:4];

  assign rd_qual = axi_rd_vld & (axi_rd_region == AXI_RSP_FIFO_REGION);
  assign rd_sel  = decode_ofs(axi_rd_addr[3:0]);
  assign stat_rd = rd_qual & (rd_sel == RD_STAT);
  assign pop     = rd_qual & (rd_sel == RD_DATA) & ~empty;

  // Ready comes from the registered count only; a pop in the same cycle
  // does not open room for a push.
  assign rsp_buff_ctrl_rdy = ~full;
  assign rsp_buff_empty    = empty;
  assign push              = ctrl_rsp_buff_vld & rsp_buff_ctrl_rdy;
  assign ovf_set           = ctrl_rsp_buff_vld & ~rsp_buff_ctrl_rdy;

  rsp_fifo_core #(
    .ENT_NUM   (ENT_NUM),
    .DATA_SIZE (RDATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ctrl_rsp_buff_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    stat_word                     = '0;
    stat_word[RSP_STAT_OVF_BIT]   = ovf;
    stat_word[RSP_STAT_FULL_BIT]  = full;
    stat_word[RSP_STAT_EMPTY_BIT] = empty;
    stat_word[CNT_WIDTH-1:0]      = count;
  end

  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    case (rd_sel)
      RD_DATA: begin
        rsp_data = empty ? '0 : head_data;
        rsp_err  = empty;
      end
      RD_STAT: rsp_data = stat_word;
      default: rsp_err  = 1'b1;
    endcase
  end

  // Sticky overflow; a new overflow beats the clear-on-status-read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (stat_rd) begin
      ovf <= 1'b0;
    end
  end

  // Stage p1: registered read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_rd_done <= 1'b0;
      axi_rd_err  <= 1'b0;
      axi_rd_data <= '0;
    end else begin
      axi_rd_done <= rd_qual;
      if (rd_qual) begin
        axi_rd_err  <= rsp_err;
        axi_rd_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_rsp_buff.sv
module tb_rsp_buff;

  localparam int ENT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_rd_vld;
  logic [10:0] axi_rd_addr;
  logic [1:0]  axi_rd_region;
  logic [31:0] axi_rd_data;
  logic        axi_rd_done;
  logic        axi_rd_err;
  logic        ctrl_rsp_buff_vld;
  logic [31:0] ctrl_rsp_buff_data;
  logic        rsp_buff_ctrl_rdy;
  logic        rsp_buff_empty;

  int checks = 0;
  int errors = 0;

  rsp_buff #(.ARADDR_WIDTH(11), .RDATA_WIDTH(32), .ENT_NUM(ENT)) dut (
    .clk                (clk),
    .rst                (rst),
    .axi_rd_vld         (axi_rd_vld),
    .axi_rd_addr        (axi_rd_addr),
    .axi_rd_region      (axi_rd_region),
    .axi_rd_data        (axi_rd_data),
    .axi_rd_done        (axi_rd_done),
    .axi_rd_err         (axi_rd_err),
    .ctrl_rsp_buff_vld  (ctrl_rsp_buff_vld),
    .ctrl_rsp_buff_data (ctrl_rsp_buff_data),
    .rsp_buff_ctrl_rdy  (rsp_buff_ctrl_rdy),
    .rsp_buff_empty     (rsp_buff_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] q[$];
  bit          m_ovf;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_data;

  initial begin
    m_ovf = 0; m_done = 0; m_err = 0; m_data = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_ovf = 0; m_done = 0; m_err = 0; m_data = 0;
      end else begin
        int  sz0;
        bit  stat_rd;
        bit  drop;
        sz0     = q.size();
        stat_rd = 0;
        drop    = 0;
        m_done  = axi_rd_vld && (axi_rd_region == 2'b10);
        if (m_done) begin
          if (axi_rd_addr[3:0] == 4'h0) begin
            if (sz0 > 0) begin m_data = q.pop_front(); m_err = 0; end
            else begin m_data = 0; m_err = 1; end
          end else if (axi_rd_addr[3:0] == 4'h4) begin
            m_data = 0;
            m_data[31] = m_ovf;
            m_data[9]  = (sz0 == ENT);
            m_data[8]  = (sz0 == 0);
            m_data[7:0] = 8'(sz0);
            m_err = 0;
            stat_rd = 1;
          end else begin
            m_data = 0; m_err = 1;
          end
        end
        if (ctrl_rsp_buff_vld) begin
          if (sz0 < ENT) q.push_back(ctrl_rsp_buff_data);
          else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (stat_rd) m_ovf = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("done", {31'b0, axi_rd_done}, {31'b0, m_done});
        if (m_done) begin
          chk("err",  {31'b0, axi_rd_err}, {31'b0, m_err});
          chk("data", axi_rd_data, m_data);
        end
        chk("rdy",   {31'b0, rsp_buff_ctrl_rdy}, {31'b0, (q.size() != ENT)});
        chk("empty", {31'b0, rsp_buff_empty},    {31'b0, (q.size() == 0)});
      end
    end
  end

  // One cycle of stimulus, applied at a negedge; returns at the next negedge
  // with the registered response of that cycle visible.
  task automatic step(input bit rv, input logic [3:0] ofs, input logic [1:0] rg,
                      input bit pv, input logic [31:0] pd);
    axi_rd_vld         = rv;
    axi_rd_addr        = {7'b0, ofs};
    axi_rd_region      = rg;
    ctrl_rsp_buff_vld  = pv;
    ctrl_rsp_buff_data = pd;
    @(negedge clk);
    axi_rd_vld        = 1'b0;
    ctrl_rsp_buff_vld = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [3:0] ofs, input bit e_err,
                        input logic [31:0] e_data);
    step(1, ofs, 2'b10, 0, 32'h0);
    chk({name, "_done"}, {31'b0, axi_rd_done}, 32'd1);
    chk({name, "_err"},  {31'b0, axi_rd_err},  {31'b0, e_err});
    chk({name, "_data"}, axi_rd_data, e_data);
  endtask

  task automatic push(input logic [31:0] d);
    step(0, 4'h0, 2'b10, 1, d);
  endtask

  initial begin
    rst = 1'b1;
    axi_rd_vld = 0; axi_rd_addr = '0; axi_rd_region = '0;
    ctrl_rsp_buff_vld = 0; ctrl_rsp_buff_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",  {31'b0, axi_rd_done},       32'd0);
    chk("rst_rdy",   {31'b0, rsp_buff_ctrl_rdy}, 32'd1);
    chk("rst_empty", {31'b0, rsp_buff_empty},    32'd1);
    chk("rst_data",  axi_rd_data,                32'd0);
    rst = 1'b0;

    // Idle reads
    rd_lit("idle_stat", 4'h4, 0, 32'h0000_0100);
    rd_lit("idle_pop",  4'h0, 1, 32'h0);

    // Basic order
    push(32'hA1); push(32'hA2); push(32'hA3);
    rd_lit("a1", 4'h0, 0, 32'hA1);
    rd_lit("a2", 4'h0, 0, 32'hA2);
    rd_lit("a3", 4'h0, 0, 32'hA3);
    rd_lit("a_empty", 4'h0, 1, 32'h0);
    chk("a_empty_flag", {31'b0, rsp_buff_empty}, 32'd1);

    // Overflow
    push(32'hB0); push(32'hB1); push(32'hB2); push(32'hB3);
    chk("full_rdy", {31'b0, rsp_buff_ctrl_rdy}, 32'd0);
    push(32'hB4);
    rd_lit("ovf_stat1", 4'h4, 0, 32'h8000_0204);
    rd_lit("ovf_stat2", 4'h4, 0, 32'h0000_0204);

    // Full FIFO, push and pop together: pop ok, push dropped
    step(1, 4'h0, 2'b10, 1, 32'hC0);
    chk("full_pp_data", axi_rd_data, 32'hB0);
    rd_lit("full_pp_stat", 4'h4, 0, 32'h8000_0003);
    rd_lit("b1", 4'h0, 0, 32'hB1);
    rd_lit("b2", 4'h0, 0, 32'hB2);
    rd_lit("b3", 4'h0, 0, 32'hB3);

    // Two entries, push and pop together
    push(32'hC3); push(32'hC4);
    step(1, 4'h0, 2'b10, 1, 32'hC5);
    chk("pp2_data", axi_rd_data, 32'hC3);
    rd_lit("pp2_stat", 4'h4, 0, 32'h0000_0002);
    rd_lit("c4", 4'h0, 0, 32'hC4);
    rd_lit("c5", 4'h0, 0, 32'hC5);

    // Empty, push and pop together: pop errors, push lands
    step(1, 4'h0, 2'b10, 1, 32'hE0);
    chk("pp0_err",  {31'b0, axi_rd_err}, 32'd1);
    chk("pp0_data", axi_rd_data, 32'h0);
    rd_lit("e0", 4'h0, 0, 32'hE0);

    // Pointer wrap with back-to-back push/pop pairs
    push(32'h10);
    for (int i = 1; i < 10; i++) begin
      step(1, 4'h0, 2'b10, 1, 32'h10 + 32'(i));
      chk("wrap_data", axi_rd_data, 32'h10 + 32'(i - 1));
    end
    rd_lit("wrap_last", 4'h0, 0, 32'h19);

    // Foreign regions and bad offset
    push(32'h55);
    step(1, 4'h0, 2'b01, 0, 32'h0);
    chk("reg01_done", {31'b0, axi_rd_done}, 32'd0);
    step(1, 4'h0, 2'b00, 0, 32'h0);
    chk("reg00_done", {31'b0, axi_rd_done}, 32'd0);
    step(1, 4'h0, 2'b11, 0, 32'h0);
    chk("reg11_done", {31'b0, axi_rd_done}, 32'd0);
    rd_lit("bad_ofs", 4'h8, 1, 32'h0);
    rd_lit("keep55", 4'h0, 0, 32'h55);

    // Reset with three entries and a read in flight
    push(32'hD1); push(32'hD2); push(32'hD3);
    axi_rd_vld = 1'b1; axi_rd_addr = 11'h0; axi_rd_region = 2'b10;
    @(posedge clk);
    #1;
    axi_rd_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_done",  {31'b0, axi_rd_done},       32'd0);
    chk("mid_rst_empty", {31'b0, rsp_buff_empty},    32'd1);
    chk("mid_rst_rdy",   {31'b0, rsp_buff_ctrl_rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rd_lit("post_rst_stat", 4'h4, 0, 32'h0000_0100);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsp_buff.md
Name: rsp_buff

Overview:
- Response buffer for the controller-to-host direction of the command path. The controller pushes 32-bit result words into a FIFO, and the host drains them with AXI reads to the response region.
- AXI read responses (data/done/err) are registered one cycle after the request.
- A non-popping status word exposes occupancy and a sticky overflow flag.

Parameters:
- ARADDR_WIDTH, 11, AXI read address width.
- RDATA_WIDTH, 32, response word width.
- ENT_NUM, 4, FIFO depth. Must be a power of 2, ≥2.
- CNT_WIDTH, $clog2(ENT_NUM)+1, occupancy counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- axi_rd_vld  in  1  single-cycle AXI read request strobe.
- axi_rd_addr  in  ARADDR_WIDTH  read address; bits [3:0] select register.
- axi_rd_region  in  2  address region decode.
- axi_rd_data  out  RDATA_WIDTH  read data, valid while axi_rd_done=1.
- axi_rd_done  out  1  one-cycle pulse; completes a region-matched read.
- axi_rd_err  out  1  qualifies axi_rd_done; SLVERR.
- ctrl_rsp_buff_vld  in  1  controller push strobe.
- ctrl_rsp_buff_data  in  RDATA_WIDTH  controller push data.
- rsp_buff_ctrl_rdy  out  1  FIFO can accept a push this cycle.
- rsp_buff_empty  out  1  FIFO empty.

Behaviour:
- Reset: all pointers, count, ovf, axi_rd_data=0, axi_rd_done=0, axi_rd_err=0. Outputs rsp_buff_ctrl_rdy=1 and rsp_buff_empty=1. Storage contents are not reset.
- rd_qual = axi_rd_vld & (axi_rd_region==AXI_RSP_FIFO_REGION). Reads to other regions are ignored (no done).
- Offset RSP_DATA_OFS (0x0), pop path:
  - if count≠0: pop head, axi_rd_data←head, err=0.
  - if empty: no pop, axi_rd_data←0, err=1.
- Offset RSP_STAT_OFS (0x4), status path: no pop, err=0.
  - axi_rd_data←{ovf at bit 31, zeros, full at bit 9, empty at bit 8, count zero-extended in bits [7:0]}.
  - ovf clears in the same cycle, unless a new overflow occurs that cycle (set wins).
- Any other offset: err=1, data 0, no state change.
- Latency: axi_rd_done/err/data are registered and appear exactly 1 cycle after rd_qual. axi_rd_done is high for 1 cycle per request; back-to-back requests give back-to-back done.
- Push and overflow:
  - rsp_buff_ctrl_rdy = (count≠ENT_NUM), derived from registered count; no same-cycle pop bypass.
  - push = ctrl_rsp_buff_vld & rdy.
  - vld while ~rdy: word dropped, ovf←1 (sticky).
- Pointers: wr_ptr/rd_ptr are $clog2(ENT_NUM) bits and wrap modulo ENT_NUM naturally. count is tracked separately: +1 on push only, −1 on pop only, unchanged on both.
- Simultaneous push and pop:
  - Non-empty and not full: both occur, count unchanged.
  - Empty: pop errors, push lands; no write-through to read data.
  - Full: rdy=0 so push drops (ovf set), pop succeeds.
- rsp_buff_empty = (count==0), combinational from count register.
- Reset mid-operation: asserted rst clears state immediately and drops a pending axi_rd_done. The host must reissue the read.

Decomposition:
- Shared defines package: AXI_RSP_FIFO_REGION (2'b10), RSP_DATA_OFS, RSP_STAT_OFS, and status bit positions (RSP_STAT_OVF_BIT=31, FULL=9, EMPTY=8).
- Sub-module rsp_fifo_core holds storage, pointers and count. It has ports push, push_data, pop, head_data, count, full, empty, with parameters ENT_NUM and DATA_SIZE.
- rsp_buff holds the AXI decode, ovf flag and response registers.

Test Plan:
- After reset, read offset 0x4 → next cycle done=1, err=0, data=0x0000_0100 (empty, count 0). Read offset 0x0 → done=1, err=1, data=0.
- Push 0xA1,0xA2,0xA3 on consecutive cycles, then three reads at 0x0 → data 0xA1,0xA2,0xA3 in order, err=0. Fourth read → err=1, empty=1.
- Push 5 words 0xB0..0xB4 with ENT_NUM=4 → rdy=0 after the 4th push, 0xB4 dropped. Status read → 0x8000_0204. Second status read → 0x0000_0204 (ovf cleared).
- With 2 entries, push 0xC5 and pop in the same cycle → read data = oldest entry, count stays 2. With full FIFO, push+pop in the same cycle → pop ok, push dropped, ovf=1.
- 10 push/pop pairs through depth 4 (pointer wrap) → data order preserved (0x10..0x19). Reads with region≠2'b10 → no done. Offset 0x8 → err=1.
- Assert rst with 3 entries and a read in flight → next cycle done=0, empty=1, rdy=1. A status read after release returns 0x0000_0100.
